pito_fetch: RTL

PITO_FETCH -- requirements
Module: pito_fetch

---
 rtl/rv32_pkg.sv | 40 ++++
 rtl/pito_pc_file.sv | 52 +++++
 rtl/pito_fetch.sv | 135 +++++++++++++
 3 files changed

// File: rtl/rv32_pkg.sv
// ---- rv32_pkg : shared RV32 fetch types, widths and exception causes (rev 1.0) ----
`default_nettype none

`ifndef PITO_NUM_HARTS
`define PITO_NUM_HARTS 8
`endif

`ifndef PITO_INSTR_MEM_ADDR_WIDTH
`define PITO_INSTR_MEM_ADDR_WIDTH 10
`endif

package rv32_pkg;

  // Hart ids are one bit wider than 8 harts need, so out-of-range ids are representable.
  localparam int HART_CNT_WIDTH  = 4;
  localparam int IMEM_ADDR_WIDTH = `PITO_INSTR_MEM_ADDR_WIDTH;

  typedef logic [31:0]                rv32_pc_cnt_t;
  typedef logic [31:0]                rv32_instr_t;
  typedef logic [HART_CNT_WIDTH-1:0]  rv32_hart_cnt_t;
  typedef logic [IMEM_ADDR_WIDTH-1:0] pito_imem_addr_t;
  typedef logic [3:0]                 exc_cause_t;

  localparam exc_cause_t EXC_INSTR_ADDR_MISALIGNED = 4'd0;

  typedef struct packed {
    logic       valid;
    exc_cause_t cause;
  } exception_t;

  typedef struct packed {
    logic           valid;
    rv32_hart_cnt_t hart;
    rv32_pc_cnt_t   pc;
    rv32_instr_t    instr;
  } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/pito_pc_file.sv
// ---- pito_pc_file : round-robin hart counter and per-hart PC registers (rev 1.0) ----
`default_nettype none

module pito_pc_file
  import rv32_pkg::*;
#(
  parameter int           NUM_HARTS = `PITO_NUM_HARTS,
  parameter rv32_pc_cnt_t RESET_PC  = 32'h0000_0000
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           advance,
  input  logic           squash_valid,
  input  rv32_hart_cnt_t squash_hart,
  input  logic           load_valid,
  input  rv32_pc_cnt_t   load_pc,
  output rv32_hart_cnt_t hart,
  output rv32_pc_cnt_t   pc
);

  localparam rv32_hart_cnt_t LAST_HART = rv32_hart_cnt_t'(NUM_HARTS - 1);

  rv32_pc_cnt_t pc_q [NUM_HARTS];

  always_comb begin
    pc = RESET_PC;
    for (int h = 0; h < NUM_HARTS; h++) begin
      if (hart == rv32_hart_cnt_t'(h)) pc = pc_q[h];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hart <= '0;
      for (int h = 0; h < NUM_HARTS; h++) pc_q[h] <= RESET_PC;
    end else begin
      if (advance) hart <= (hart == LAST_HART) ? '0 : hart + rv32_hart_cnt_t'(1);
      // A squashed fetch must not advance its PC, otherwise that instruction is skipped.
      for (int h = 0; h < NUM_HARTS; h++) begin
        if (load_valid && squash_hart == rv32_hart_cnt_t'(h)) begin
          pc_q[h] <= load_pc;
        end else if (advance && hart == rv32_hart_cnt_t'(h) &&
                     !(squash_valid && squash_hart == rv32_hart_cnt_t'(h))) begin
          pc_q[h] <= pc_q[h] + 32'd4;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/pito_fetch.sv
// ---- pito_fetch : barrel-hart fetch stage with 1-entry skid buffer (rev 1.0) ----
// Define PITO_FETCH_MISALIGN_CHK_EN to reject misaligned redirects and report them on exc_o.
`default_nettype none

module pito_fetch
  import rv32_pkg::*;
#(
  parameter int           NUM_HARTS = `PITO_NUM_HARTS,
  parameter rv32_pc_cnt_t RESET_PC  = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_i,
  output logic            imem_req_o,
  output pito_imem_addr_t imem_addr_o,
  input  rv32_instr_t     imem_rdata_i,
  input  logic            redirect_valid_i,
  input  rv32_hart_cnt_t  redirect_hart_i,
  input  rv32_pc_cnt_t    redirect_pc_i,
  output logic            instr_valid_o,
  output rv32_instr_t     instr_o,
  output rv32_pc_cnt_t    instr_pc_o,
  output rv32_hart_cnt_t  instr_hart_o
`ifdef PITO_FETCH_MISALIGN_CHK_EN
  ,
  output exception_t      exc_o
`endif
);

  localparam rv32_hart_cnt_t LAST_HART = rv32_hart_cnt_t'(NUM_HARTS - 1);

  logic           fetch;
  logic           redir_hit;
  logic           redir_misalign;
  logic           redir_load;
  rv32_hart_cnt_t cur_hart;
  rv32_pc_cnt_t   cur_pc;

  logic           flight_valid;
  rv32_hart_cnt_t flight_hart;
  rv32_pc_cnt_t   flight_pc;

  fetch_entry_t   resp;
  fetch_entry_t   out_q;
  fetch_entry_t   skid_q;
  logic           skid_live;
  logic           out_live;

  assign fetch     = !stall_i && !rst;
  assign redir_hit = redirect_valid_i && (redirect_hart_i <= LAST_HART);
`ifdef PITO_FETCH_MISALIGN_CHK_EN
  assign redir_misalign = |redirect_pc_i[1:0];
`else
  assign redir_misalign = 1'b0;
`endif
  assign redir_load = redir_hit && !redir_misalign;

  pito_pc_file #(
    .NUM_HARTS (NUM_HARTS),
    .RESET_PC  (RESET_PC)
  ) u_pc_file (
    .clk          (clk),
    .rst          (rst),
    .advance      (!stall_i),
    .squash_valid (redir_hit),
    .squash_hart  (redirect_hart_i),
    .load_valid   (redir_load),
    .load_pc      (redirect_pc_i & ~rv32_pc_cnt_t'(3)),
    .hart         (cur_hart),
    .pc           (cur_pc)
  );

  assign imem_req_o  = fetch;
  assign imem_addr_o = cur_pc[IMEM_ADDR_WIDTH+1:2];

  always_comb begin
    resp.valid = flight_valid && !(redir_hit && flight_hart == redirect_hart_i);
    resp.hart  = flight_hart;
    resp.pc    = flight_pc;
    resp.instr = imem_rdata_i;
    skid_live  = skid_q.valid && !(redir_hit && skid_q.hart == redirect_hart_i);
    out_live   = out_q.valid && !(redir_hit && out_q.hart == redirect_hart_i);
  end

  // While stalled the output holds and any returning response parks in the skid slot;
  // only one fetch can be outstanding across a stall, so one slot is enough.
  always_ff @(posedge clk) begin
    if (rst) begin
      flight_valid <= 1'b0;
      flight_hart  <= '0;
      flight_pc    <= '0;
      out_q        <= '0;
      skid_q       <= '0;
    end else begin
      flight_valid <= fetch && !(redir_hit && redirect_hart_i == cur_hart);
      flight_hart  <= cur_hart;
      flight_pc    <= cur_pc;
      if (stall_i) begin
        out_q.valid <= out_live;
        if (resp.valid) skid_q       <= resp;
        else            skid_q.valid <= skid_live;
      end else if (skid_live) begin
        out_q  <= skid_q;
        skid_q <= resp;
      end else begin
        if (resp.valid) out_q       <= resp;
        else            out_q.valid <= 1'b0;
        skid_q.valid <= 1'b0;
      end
    end
  end

  assign instr_valid_o = out_q.valid;
  assign instr_o       = out_q.instr;
  assign instr_pc_o    = out_q.pc;
  assign instr_hart_o  = out_q.hart;

`ifdef PITO_FETCH_MISALIGN_CHK_EN
  exception_t exc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      exc_q <= '0;
    end else begin
      exc_q.valid <= redir_hit && redir_misalign;
      exc_q.cause <= EXC_INSTR_ADDR_MISALIGNED;
    end
  end

  assign exc_o = exc_q;
`endif

endmodule

`default_nettype wire
